// File: rtl/adc_event_builder.sv
// ADC event builder: captures one read window of ADC samples into a block RAM,
// then streams a header word followed by the samples on an AXI-Stream style
// output. Read windows that arrive while an event is in progress are counted
// as drops and otherwise ignored.
module adc_event_builder #(
  parameter int NUM_DATA               = 1280,
  parameter int ADC_WIDTH              = 12,
  parameter int TRIGGER_COUNTER_LENGTH = 16,
  parameter int DROP_COUNTER_LENGTH    = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              adc_read_en,
  input  logic [ADC_WIDTH-1:0]              adc_data,
  input  logic [TRIGGER_COUNTER_LENGTH-1:0] trigger_counter,
  output logic [31:0]                       m_tdata,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              m_tlast,
  output logic                              busy,
  output logic [DROP_COUNTER_LENGTH-1:0]    dropped_count
);

  localparam int ADDR_W = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;
  localparam int CNT_W  = $clog2(NUM_DATA + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_DATA);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    HEADER,
    STREAM
  } state_t;

  state_t                              state_q, state_d;
  logic                                read_en_q;
  logic                                armed_q;
  logic [TRIGGER_COUNTER_LENGTH-1:0]   trig_q, trig_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [ADDR_W-1:0]                   rd_addr_q, rd_addr_d;
  logic [31:0]                         tdata_q, tdata_d;
  logic                                tvalid_q, tvalid_d;
  logic                                tlast_q, tlast_d;
  logic                                busy_q;
  logic [DROP_COUNTER_LENGTH-1:0]      drop_q, drop_d;

  logic [ADC_WIDTH-1:0]                mem [NUM_DATA];
  logic [ADC_WIDTH-1:0]                rd_data_q;
  logic                                wr_en;
  logic [ADDR_W-1:0]                   wr_addr;
  logic                                rise;
  logic                                out_hs;
  logic                                load_word;
  logic                                load_last;
  logic                                goto_header;

  // armed_q masks the first cycle after reset so a read_en level that is
  // already high at reset release is not mistaken for a new window.
  assign rise   = adc_read_en & ~read_en_q & armed_q;
  assign out_hs = tvalid_q & m_tready;

  assign m_tdata       = tdata_q;
  assign m_tvalid      = tvalid_q;
  assign m_tlast       = tlast_q;
  assign busy          = busy_q;
  assign dropped_count = drop_q;

  // Sample buffer: one write port, registered read. The read address is the
  // next-state address so rd_data_q always holds mem[rd_addr_q].
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= adc_data;
    end
    rd_data_q <= mem[rd_addr_d];
  end

  // Next-state, capture control and output-word selection.
  always_comb begin
    state_d     = state_q;
    trig_d      = trig_q;
    cnt_d       = cnt_q;
    rd_addr_d   = rd_addr_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    drop_d      = drop_q;
    wr_en       = 1'b0;
    wr_addr     = ADDR_W'(cnt_q);
    load_word   = 1'b0;
    load_last   = 1'b0;
    goto_header = 1'b0;

    // A new window while an event is in flight is only counted.
    if (rise && (state_q != IDLE) && !(&drop_q)) begin
      drop_d = drop_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        rd_addr_d = '0;
        if (rise) begin
          wr_en   = 1'b1;
          wr_addr = '0;
          cnt_d   = CNT_ONE;
          trig_d  = trigger_counter;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rd_addr_d = '0;
        if (!adc_read_en || (cnt_q == CNT_MAX)) begin
          goto_header = 1'b1;
        end else begin
          wr_en = 1'b1;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == CNT_MAX) begin
            goto_header = 1'b1;
          end
        end
        if (goto_header) begin
          state_d  = HEADER;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = {16'(trig_q), 16'(cnt_d)};
        end
      end
      HEADER: begin
        if (out_hs) begin
          load_word = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (out_hs) begin
          if (tlast_q) begin
            state_d   = IDLE;
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            tdata_d   = '0;
            rd_addr_d = '0;
          end else begin
            load_word = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Move the prefetched sample into the output register and advance the
    // read pointer unless this was the final sample of the event.
    if (load_word) begin
      load_last = (CNT_W'(rd_addr_q) == (cnt_q - CNT_ONE));
      tdata_d   = 32'(rd_data_q);
      tlast_d   = load_last;
      rd_addr_d = load_last ? rd_addr_q : rd_addr_q + ADDR_W'(1);
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      read_en_q <= 1'b0;
      armed_q   <= 1'b0;
      trig_q    <= '0;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      read_en_q <= adc_read_en;
      armed_q   <= 1'b1;
      trig_q    <= trig_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      busy_q    <= (state_d != IDLE);
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_adc_event_builder.sv
// Scoreboard bench for adc_event_builder: stimulus pushes expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_adc_event_builder;

  localparam int NUM_DATA = 1280;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        adc_read_en = 1'b0;
  logic [11:0] adc_data = '0;
  logic [15:0] trigger_counter = '0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        busy;
  logic [15:0] dropped_count;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          hs_count = 0;
  bit          rand_ready = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic [11:0] abc [3] = '{12'hABC, 12'h123, 12'hFED};

  adc_event_builder #(
    .NUM_DATA(NUM_DATA),
    .ADC_WIDTH(12),
    .TRIGGER_COUNTER_LENGTH(16),
    .DROP_COUNTER_LENGTH(16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .adc_read_en(adc_read_en),
    .adc_data(adc_data),
    .trigger_counter(trigger_counter),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast(m_tlast),
    .busy(busy),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Downstream ready: always high, or a 50% random pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare each handshaken word with the scoreboard and check that
  // a stalled word holds stable.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {31'd0, m_tvalid, m_tdata, m_tlast}, {31'd0, 1'b1, prev_data, prev_last});
      end
      if (m_tvalid && m_tready) begin
        hs_count++;
        $display("word %0d data=0x%08h last=%0b", hs_count, m_tdata, m_tlast);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got 0x%08h expected no word", m_tdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("word", {31'd0, m_tdata, m_tlast}, {31'd0, e.data, e.last});
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end
  end

  // Push the expected event, then drive a read window of n cycles.
  task automatic run_window(input int n, input logic [15:0] trig, input int kind);
    int   cnt;
    exp_t e;
    cnt = (n < NUM_DATA) ? n : NUM_DATA;
    e.data = {trig, 16'(cnt)};
    e.last = 1'b0;
    sb.push_back(e);
    for (int i = 0; i < cnt; i++) begin
      e.data = (kind == 0) ? 32'(12'(i)) : 32'(abc[i]);
      e.last = (i == cnt - 1);
      sb.push_back(e);
    end
    adc_read_en     = 1'b1;
    trigger_counter = trig;
    for (int i = 0; i < n; i++) begin
      adc_data = (kind == 0) ? 12'(i) : abc[i];
      @(posedge clk);
      #1;
      trigger_counter = trig + 16'd100;
    end
    adc_read_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int c;
    c = 0;
    while ((busy || sb.size() != 0) && c < budget) begin
      tick(1);
      c++;
    end
    checks++;
    if (busy || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got busy=%0b pending=%0d expected idle with 0 pending", name, busy, sb.size());
      sb.delete();
    end
    check({name, "_tvalid_after"}, 64'(m_tvalid), 64'd0);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int c;
    c = 0;
    while (hs_count < target && c < budget) begin
      tick(1);
      c++;
    end
    check("wait_handshakes", 64'(hs_count >= target), 64'd1);
  endtask

  initial begin
    int base;
    rstn = 1'b0;
    tick(3);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dropped", 64'(dropped_count), 64'd0);
    rstn = 1'b1;
    tick(2);

    // Full 1280-sample ramp window.
    run_window(1280, 16'd5, 0);
    wait_idle("full", 3000);
    check("full_busy", 64'(busy), 64'd0);
    check("full_dropped", 64'(dropped_count), 64'd0);
    tick(3);

    // Short 3-sample window.
    run_window(3, 16'd9, 1);
    wait_idle("short", 100);
    tick(3);

    // Overlong window: only the first 1280 samples survive.
    run_window(1300, 16'd6, 0);
    wait_idle("overlong", 3000);
    check("overlong_dropped", 64'(dropped_count), 64'd0);
    tick(3);

    // Random backpressure on a short event.
    rand_ready = 1'b1;
    run_window(3, 16'd7, 1);
    wait_idle("backpressure", 500);
    rand_ready = 1'b0;
    tick(3);

    // Drop: a second window during STREAM, then a normal third window.
    base = hs_count;
    run_window(20, 16'd8, 0);
    wait_hs(base + 4, 200);
    adc_read_en = 1'b1;
    adc_data    = 12'h777;
    tick(2);
    adc_read_en = 1'b0;
    check("drop_busy", 64'(busy), 64'd1);
    wait_idle("drop_first", 200);
    check("drop_count", 64'(dropped_count), 64'd1);
    tick(3);
    run_window(3, 16'd11, 1);
    wait_idle("drop_third", 100);
    check("drop_count_after", 64'(dropped_count), 64'd1);
    tick(3);

    // Reset in STREAM after the header and two sample words.
    base = hs_count;
    run_window(5, 16'd12, 0);
    wait_hs(base + 3, 200);
    rstn = 1'b0;
    sb.delete();
    #1;
    check("midrst_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_dropped", 64'(dropped_count), 64'd0);
    tick(2);
    rstn = 1'b1;
    tick(20);
    check("midrst_quiet_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_quiet_busy", 64'(busy), 64'd0);
    run_window(3, 16'd13, 1);
    wait_idle("after_rst", 100);
    tick(3);

    // read_en already high at reset release is not a window.
    adc_read_en = 1'b1;
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(5);
    check("level_busy", 64'(busy), 64'd0);
    check("level_dropped", 64'(dropped_count), 64'd0);
    adc_read_en = 1'b0;
    tick(3);
    run_window(3, 16'd14, 1);
    wait_idle("level_next", 100);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/adc_event_builder.md
ADC_EVENT_BUILDER -- requirements
Module: adc_event_builder

Interface
REQ-001 Parameter NUM_DATA, default 1280, maximum samples captured per event.
REQ-002 Parameter ADC_WIDTH, default 12, ADC sample width in bits.
REQ-003 Parameter TRIGGER_COUNTER_LENGTH, default 16, event-number width.
REQ-004 Parameter DROP_COUNTER_LENGTH, default 16, dropped-event counter width.
REQ-005 clk  input  1  capture and stream clock, the same 40 MHz clock driving the ADC clock output.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 adc_read_en  input  1  read-window strobe from the trigger/readout controller; high for one window per event.
REQ-008 adc_data  input  ADC_WIDTH  deserialized ADC sample, valid on each clk edge while adc_read_en is high.
REQ-009 trigger_counter  input  TRIGGER_COUNTER_LENGTH  event number from the trigger/readout controller.
REQ-010 m_tdata  output  32  output stream data.
REQ-011 m_tvalid  output  1  output stream valid.
REQ-012 m_tready  input  1  output stream ready from the downstream DMA/FIFO.
REQ-013 m_tlast  output  1  marks the final word of an event.
REQ-014 busy  output  1  high whenever the block is not in IDLE.
REQ-015 dropped_count  output  DROP_COUNTER_LENGTH  number of read windows rejected while busy.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, CAPTURE, HEADER, STREAM.
REQ-017 IDLE->CAPTURE on a rising edge of adc_read_en (high now, low the previous cycle).
REQ-018 In the rising-edge cycle, the block SHALL write adc_data to buffer address 0 and latch trigger_counter.
REQ-019 In CAPTURE, each cycle with adc_read_en high SHALL write adc_data to the next buffer address.
REQ-020 CAPTURE->HEADER when adc_read_en is low or NUM_DATA samples have been written, whichever occurs first.
REQ-021 Samples offered after the NUM_DATA-th write in the same window SHALL be discarded.
REQ-022 sample_count SHALL equal the number of samples written, in the range 1..NUM_DATA.
REQ-023 The buffer SHALL be a single-port-write, registered-read memory of depth NUM_DATA and width ADC_WIDTH, inferable as block RAM.
REQ-024 HEADER: m_tdata SHALL be {latched trigger_counter zero-extended to 16 bits, sample_count zero-extended to 16 bits}, with m_tvalid=1 and m_tlast=0.
REQ-025 HEADER->STREAM on the first cycle in which m_tvalid and m_tready are both high.
REQ-026 STREAM: one word per sample, in write order, m_tdata = sample zero-extended to 32 bits.
REQ-027 m_tlast SHALL be 1 only on the word carrying sample sample_count-1.
REQ-028 STREAM->IDLE on the handshake of the m_tlast word.
REQ-029 While m_tvalid=1 and m_tready=0, m_tdata, m_tlast, and m_tvalid SHALL hold stable.
REQ-030 m_tvalid SHALL NOT depend combinationally on m_tready.
REQ-031 At most one cycle with m_tvalid low is permitted between the header handshake and the first sample word.
REQ-032 After the first sample word, the block SHALL present one word per cycle while m_tready is held high.
REQ-033 A rising edge of adc_read_en in CAPTURE, HEADER, or STREAM SHALL increment dropped_count, saturating at all-ones, and SHALL NOT alter the buffer or the current event.
REQ-034 A drop edge and a STREAM->IDLE transition in the same cycle SHALL count as a drop; the window SHALL NOT be captured.
REQ-035 All outputs SHALL be registered.
REQ-036 busy SHALL be high in CAPTURE, HEADER, and STREAM.

Reset
REQ-037 On rstn low: state=IDLE, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, dropped_count=0, internal counters=0, edge-detect register=0.
REQ-038 Reset asserted mid-event SHALL abandon the event with no further words emitted; buffer contents need not be cleared.
REQ-039 After rstn deasserts, if adc_read_en is already high, that level SHALL NOT count as a rising edge.

Verification
REQ-040 Full window: read_en high 1280 cycles, data=ramp 0..1279, trigger_counter=5, tready=1 -> header 0x00050500, then words 0..1279, tlast on 1279, busy low after.
REQ-041 Short window: read_en high 3 cycles, data A,B,C, trigger_counter=9 -> header 0x00090003, words A,B,C, tlast on C.
REQ-042 Overlong window: read_en high 1300 cycles -> sample_count=1280; samples 1280..1299 discarded; dropped_count unchanged.
REQ-043 Backpressure: tready random 50% during the 3-sample event -> identical word sequence; data held stable while stalled.
REQ-044 Drop: second read_en rising edge during STREAM, then a third edge after return to IDLE -> dropped_count=1; first event intact; third event captured normally.
REQ-045 Reset during STREAM after 2 words -> tvalid=0 next; with no new window, no further words; dropped_count=0; next window produces a normal event.
